// File: rtl/a_axi_write_slr_receiver.sv
// Per-SLR sink for the broadcast AXI-lite control write path: re-joins AW/W beats,
// merges data by strobe into shadow argument registers and pulses ap_start locally.
module a_axi_write_slr_receiver #(
    parameter int C_S_AXI_CONTROL_ADDR_WIDTH  = 9,
    parameter int C_S_AXI_CONTROL_DATA_WIDTH  = 32,
    parameter int C_S_AXI_CONTROL_WSTRB_WIDTH = C_S_AXI_CONTROL_DATA_WIDTH / 8,
    parameter int NUM_REGS                    = 16,
    parameter logic [C_S_AXI_CONTROL_ADDR_WIDTH-1:0] BASE_ADDR = 9'h010
) (
    input  logic                                           ap_clk,
    input  logic                                           ap_rst_n,
    input  logic                                           s_axi_control_AWVALID,
    output logic                                           s_axi_control_AWREADY,
    input  logic [C_S_AXI_CONTROL_ADDR_WIDTH-1:0]          s_axi_control_AWADDR,
    input  logic                                           s_axi_control_WVALID,
    output logic                                           s_axi_control_WREADY,
    input  logic [C_S_AXI_CONTROL_DATA_WIDTH-1:0]          s_axi_control_WDATA,
    input  logic [C_S_AXI_CONTROL_WSTRB_WIDTH-1:0]         s_axi_control_WSTRB,
    output logic [NUM_REGS*C_S_AXI_CONTROL_DATA_WIDTH-1:0] regs_flat,
    output logic                                           ap_start_pulse,
    output logic                                           decode_err,
    output logic [15:0]                                    write_count
);

    localparam int AW    = C_S_AXI_CONTROL_ADDR_WIDTH;
    localparam int DW    = C_S_AXI_CONTROL_DATA_WIDTH;
    localparam int SW    = C_S_AXI_CONTROL_WSTRB_WIDTH;
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [31:0] BASE32 = 32'(BASE_ADDR);
    localparam logic [31:0] END32  = BASE32 + 32'(4 * NUM_REGS);

    // State encoding is {aw_full, w_full} so slot occupancy falls straight out of it.
    typedef enum logic [1:0] {
        EMPTY   = 2'b00,
        HAVE_W  = 2'b01,
        HAVE_AW = 2'b10,
        COMMIT  = 2'b11
    } state_t;

    state_t            state, state_next;
    logic [AW-1:0]     aw_addr;
    logic [DW-1:0]     w_data;
    logic [SW-1:0]     w_strb;
    logic [DW-1:0]     regs [NUM_REGS];
    logic              aw_full, w_full, aw_acc, w_acc;
    logic [AW-1:0]     word_addr, offset;
    logic [31:0]       addr32;
    logic [IDX_W-1:0]  idx;
    logic              is_ctrl, in_range;
    logic              unused_bits;

    assign aw_full = state[1];
    assign w_full  = state[0];

    // READYs are held low during reset even though the slots already read as empty.
    assign s_axi_control_AWREADY = ap_rst_n & ~aw_full;
    assign s_axi_control_WREADY  = ap_rst_n & ~w_full;
    assign aw_acc = s_axi_control_AWVALID & s_axi_control_AWREADY;
    assign w_acc  = s_axi_control_WVALID & s_axi_control_WREADY;

    assign word_addr   = {aw_addr[AW-1:2], 2'b00};
    assign offset      = word_addr - BASE_ADDR;
    assign addr32      = 32'(word_addr);
    assign idx         = offset[IDX_W+1:2];
    assign is_ctrl     = (word_addr == '0);
    assign in_range    = (addr32 >= BASE32) && (addr32 < END32);
    assign unused_bits = &{1'b0, offset[1:0], offset[AW-1:IDX_W+2]};

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state <= EMPTY;
        else           state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: begin
                if (aw_acc && w_acc) state_next = COMMIT;
                else if (aw_acc)     state_next = HAVE_AW;
                else if (w_acc)      state_next = HAVE_W;
            end
            HAVE_AW: if (w_acc)  state_next = COMMIT;
            HAVE_W:  if (aw_acc) state_next = COMMIT;
            COMMIT:  state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            aw_addr <= '0;
            w_data  <= '0;
            w_strb  <= '0;
        end else begin
            if (aw_acc) aw_addr <= s_axi_control_AWADDR;
            if (w_acc) begin
                w_data <= s_axi_control_WDATA;
                w_strb <= s_axi_control_WSTRB;
            end
        end
    end

    // Commit happens on the edge that leaves COMMIT; pulses last exactly one cycle.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            ap_start_pulse <= 1'b0;
            decode_err     <= 1'b0;
            write_count    <= '0;
        end else begin
            ap_start_pulse <= 1'b0;
            decode_err     <= 1'b0;
            if (state == COMMIT) begin
                write_count <= write_count + 16'd1;
                if (is_ctrl) begin
                    ap_start_pulse <= w_strb[0] & w_data[0];
                end else if (in_range) begin
                    for (int k = 0; k < SW; k++) begin
                        if (w_strb[k]) regs[idx][k*8 +: 8] <= w_data[k*8 +: 8];
                    end
                end else begin
                    decode_err <= 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*DW +: DW] = regs[g];
    end

endmodule

// File: tb/tb_a_axi_write_slr_receiver.sv
// Directed self-checking bench for a_axi_write_slr_receiver; inputs change 1ns after
// each rising edge and outputs are sampled at that same point.
module tb_a_axi_write_slr_receiver;

    logic         ap_clk = 1'b0;
    logic         ap_rst_n = 1'b0;
    logic         awvalid = 1'b0;
    logic         awready;
    logic [8:0]   awaddr = '0;
    logic         wvalid = 1'b0;
    logic         wready;
    logic [31:0]  wdata = '0;
    logic [3:0]   wstrb = '0;
    logic [511:0] regs_flat;
    logic         ap_start_pulse;
    logic         decode_err;
    logic [15:0]  write_count;

    int vectors = 0;
    int miscompares = 0;

    a_axi_write_slr_receiver dut (
        .ap_clk                (ap_clk),
        .ap_rst_n              (ap_rst_n),
        .s_axi_control_AWVALID (awvalid),
        .s_axi_control_AWREADY (awready),
        .s_axi_control_AWADDR  (awaddr),
        .s_axi_control_WVALID  (wvalid),
        .s_axi_control_WREADY  (wready),
        .s_axi_control_WDATA   (wdata),
        .s_axi_control_WSTRB   (wstrb),
        .regs_flat             (regs_flat),
        .ap_start_pulse        (ap_start_pulse),
        .decode_err            (decode_err),
        .write_count           (write_count)
    );

    always #5 ap_clk = ~ap_clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 200us");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    function automatic logic [31:0] reg_at(input int i);
        return regs_flat[i*32 +: 32];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Presents both beats together for one edge, then drops VALIDs.
    task automatic applyStimulus(input logic [8:0] addr, input logic [31:0] data, input logic [3:0] strb);
        awvalid = 1'b1; awaddr = addr;
        wvalid  = 1'b1; wdata  = data; wstrb = strb;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        checkOutput("rst_awready", 32'(awready), 32'd0);
        checkOutput("rst_wready", 32'(wready), 32'd0);
        checkOutput("rst_regs_any", 32'(|regs_flat), 32'd0);
        checkOutput("rst_count", 32'(write_count), 32'd0);
        ap_rst_n = 1'b1;
        tick();
        checkOutput("idle_awready", 32'(awready), 32'd1);
        checkOutput("idle_wready", 32'(wready), 32'd1);

        // Simultaneous full-word write to reg0
        applyStimulus(9'h010, 32'hDEADBEEF, 4'hF);
        checkOutput("t1_awready_low", 32'(awready), 32'd0);
        checkOutput("t1_wready_low", 32'(wready), 32'd0);
        checkOutput("t1_count_pre", 32'(write_count), 32'd0);
        tick();
        checkOutput("t1_awready_back", 32'(awready), 32'd1);
        checkOutput("t1_wready_back", 32'(wready), 32'd1);
        checkOutput("t1_reg0", reg_at(0), 32'hDEADBEEF);
        checkOutput("t1_count", 32'(write_count), 32'd1);

        // AW first, W five cycles later, partial strobe merge into reg1
        applyStimulus(9'h014, 32'hAABBCCDD, 4'hF);
        tick();
        checkOutput("t2_reg1_init", reg_at(1), 32'hAABBCCDD);
        awvalid = 1'b1; awaddr = 9'h014;
        tick();
        awvalid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            checkOutput($sformatf("t2_awready_c%0d", c), 32'(awready), 32'd0);
            tick();
        end
        checkOutput("t2_wready_open", 32'(wready), 32'd1);
        wvalid = 1'b1; wdata = 32'h12345678; wstrb = 4'b0101;
        tick();
        wvalid = 1'b0;
        checkOutput("t2_awready_c6", 32'(awready), 32'd0);
        tick();
        checkOutput("t2_awready_back", 32'(awready), 32'd1);
        checkOutput("t2_reg1_merge", reg_at(1), 32'hAA34CC78);
        checkOutput("t2_count", 32'(write_count), 32'd3);

        // Control write fires ap_start for exactly one cycle
        applyStimulus(9'h000, 32'h00000001, 4'h1);
        checkOutput("t3_pulse_pre", 32'(ap_start_pulse), 32'd0);
        tick();
        checkOutput("t3_pulse", 32'(ap_start_pulse), 32'd1);
        checkOutput("t3_count", 32'(write_count), 32'd4);
        checkOutput("t3_reg0_kept", reg_at(0), 32'hDEADBEEF);
        checkOutput("t3_reg1_kept", reg_at(1), 32'hAA34CC78);
        tick();
        checkOutput("t3_pulse_end", 32'(ap_start_pulse), 32'd0);
        applyStimulus(9'h000, 32'h00000001, 4'h0);
        tick();
        checkOutput("t3_nostrb_pulse", 32'(ap_start_pulse), 32'd0);
        checkOutput("t3_nostrb_count", 32'(write_count), 32'd5);

        // Just past the register window
        applyStimulus(9'h050, 32'hFFFFFFFF, 4'hF);
        tick();
        checkOutput("t4_decode_err", 32'(decode_err), 32'd1);
        checkOutput("t4_count", 32'(write_count), 32'd6);
        checkOutput("t4_reg0_kept", reg_at(0), 32'hDEADBEEF);
        checkOutput("t4_reg15_kept", reg_at(15), 32'h0);
        tick();
        checkOutput("t4_err_end", 32'(decode_err), 32'd0);

        // Last word of the window, then low address bits ignored
        applyStimulus(9'h04C, 32'h0F0F0F0F, 4'hF);
        tick();
        checkOutput("t4_reg15", reg_at(15), 32'h0F0F0F0F);
        checkOutput("t4_last_noerr", 32'(decode_err), 32'd0);
        applyStimulus(9'h012, 32'h00005500, 4'b0010);
        tick();
        checkOutput("t4_lowbits_reg0", reg_at(0), 32'hDEAD55EF);
        checkOutput("t4_lowbits_count", 32'(write_count), 32'd8);

        // Three W beats ahead of their AWs
        wvalid = 1'b1; wdata = 32'h11111111; wstrb = 4'hF;
        tick();
        wdata = 32'h22222222;
        checkOutput("t5_wstall_a", 32'(wready), 32'd0);
        tick();
        checkOutput("t5_wstall_b", 32'(wready), 32'd0);
        awvalid = 1'b1; awaddr = 9'h018;
        tick();
        awaddr = 9'h01C;
        checkOutput("t5_commit_aw", 32'(awready), 32'd0);
        tick();
        checkOutput("t5_reg2", reg_at(2), 32'h11111111);
        tick();
        awaddr = 9'h020; wdata = 32'h33333333;
        tick();
        checkOutput("t5_reg3", reg_at(3), 32'h22222222);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        checkOutput("t5_reg4", reg_at(4), 32'h33333333);
        checkOutput("t5_count", 32'(write_count), 32'd11);

        // Reset while an AW is parked; a lone W afterwards must not commit
        awvalid = 1'b1; awaddr = 9'h010;
        tick();
        awvalid = 1'b0;
        ap_rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_awready", 32'(awready), 32'd0);
        checkOutput("t6_rst_wready", 32'(wready), 32'd0);
        checkOutput("t6_rst_regs", 32'(|regs_flat), 32'd0);
        tick();
        checkOutput("t6_rst_count", 32'(write_count), 32'd0);
        ap_rst_n = 1'b1;
        wvalid = 1'b1; wdata = 32'hCAFEF00D; wstrb = 4'hF;
        tick();
        wvalid = 1'b0;
        tick();
        tick();
        checkOutput("t6_no_commit_reg0", reg_at(0), 32'h0);
        checkOutput("t6_no_commit_count", 32'(write_count), 32'd0);
        checkOutput("t6_awready", 32'(awready), 32'd1);
        checkOutput("t6_wready_held", 32'(wready), 32'd0);
        awvalid = 1'b1; awaddr = 9'h010;
        tick();
        awvalid = 1'b0;
        tick();
        checkOutput("t6_reg0", reg_at(0), 32'hCAFEF00D);
        checkOutput("t6_count", 32'(write_count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
